scoreboard_issue_select: RTL and testbench

//   Downstream of the scoreboard cell array. Each cycle, picks the oldest

---
 rtl/scoreboard_issue_select_if.sv | 34 +++
 rtl/scoreboard_issue_select.sv | 126 ++++++++++++
 tb/tb_scoreboard_issue_select.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/scoreboard_issue_select_if.sv
// Issue-select bundle: scoreboard entry fields in, issue slot and busy table out.
// master = scoreboard/execute side, slave = the selector.
interface scoreboard_issue_select_if #(
   parameter int DEPTH = 4,
   parameter int IDXW  = 2
);
   logic                  flush;
   logic [DEPTH*32-1:0]   ent_instr;
   logic [DEPTH*5-1:0]    ent_rs1;
   logic [DEPTH*5-1:0]    ent_rs2;
   logic [DEPTH*5-1:0]    ent_rd;
   logic [DEPTH-1:0]      ent_running;
   logic [DEPTH-1:0]      issue_start;
   logic                  issue_valid;
   logic                  issue_ready;
   logic [31:0]           issue_instr;
   logic [4:0]            issue_rd;
   logic [IDXW-1:0]       issue_idx;
   logic                  wb_valid;
   logic [4:0]            wb_rd;
   logic [31:0]           busy;

   modport master (
      output flush, ent_instr, ent_rs1, ent_rs2, ent_rd, ent_running,
             issue_ready, wb_valid, wb_rd,
      input  issue_start, issue_valid, issue_instr, issue_rd, issue_idx, busy
   );

   modport slave (
      input  flush, ent_instr, ent_rs1, ent_rs2, ent_rd, ent_running,
             issue_ready, wb_valid, wb_rd,
      output issue_start, issue_valid, issue_instr, issue_rd, issue_idx, busy
   );
endinterface

// File: rtl/scoreboard_issue_select.sv
// Picks the oldest hazard-free scoreboard entry, pulses its start, and loads
// it into a registered valid/ready issue slot; tracks in-flight destinations.
module scoreboard_issue_select #(
   parameter int DEPTH = 4,
   parameter int IDXW  = 2
) (
   input  logic clock,
   input  logic reset_async_n,
   scoreboard_issue_select_if.slave sb
);

   logic [4:0]      rs1_a [DEPTH];
   logic [4:0]      rs2_a [DEPTH];
   logic [4:0]      rd_a  [DEPTH];
   logic [31:0]     instr_a [DEPTH];
   logic [DEPTH-1:0] elig;
   logic [DEPTH-1:0] cand;

   logic            found;
   logic [IDXW-1:0] win_idx;
   logic [31:0]     win_instr;
   logic [4:0]      win_rd;
   logic            go;

   logic            valid_q, valid_d;
   logic [31:0]     instr_q, instr_d;
   logic [4:0]      rd_q, rd_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [31:0]     busy_q, busy_d;

   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         instr_a[i] = sb.ent_instr[i*32 +: 32];
         rs1_a[i]   = sb.ent_rs1[i*5 +: 5];
         rs2_a[i]   = sb.ent_rs2[i*5 +: 5];
         rd_a[i]    = sb.ent_rd[i*5 +: 5];
         elig[i]    = (instr_a[i] != '0) && !sb.ent_running[i];
      end
   end

   // busy_q[0] is held at 0, so register 0 never blocks through the table.
   always_comb begin
      cand = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         cand[i] = elig[i] && !busy_q[rs1_a[i]] && !busy_q[rs2_a[i]] && !busy_q[rd_a[i]];
         for (int unsigned j = 0; j < i; j++) begin
            if (elig[j]) begin
               if ((rd_a[j] != '0) &&
                   ((rd_a[j] == rs1_a[i]) || (rd_a[j] == rs2_a[i]) || (rd_a[j] == rd_a[i])))
                  cand[i] = 1'b0;
               if ((rd_a[i] != '0) && ((rs1_a[j] == rd_a[i]) || (rs2_a[j] == rd_a[i])))
                  cand[i] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      found     = 1'b0;
      win_idx   = '0;
      win_instr = '0;
      win_rd    = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (cand[i] && !found) begin
            found     = 1'b1;
            win_idx   = IDXW'(i);
            win_instr = instr_a[i];
            win_rd    = rd_a[i];
         end
      end
      go = found && (!valid_q || sb.issue_ready) && !sb.flush && reset_async_n;
      sb.issue_start = go ? (DEPTH'(1) << win_idx) : '0;
   end

   // Clear before set so an issue to the same register as a writeback wins.
   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      rd_d    = rd_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      if (sb.flush) begin
         valid_d = 1'b0;
         instr_d = '0;
         rd_d    = '0;
         idx_d   = '0;
         busy_d  = '0;
      end else begin
         if (sb.wb_valid)
            busy_d[sb.wb_rd] = 1'b0;
         if (go) begin
            valid_d        = 1'b1;
            instr_d        = win_instr;
            rd_d           = win_rd;
            idx_d          = win_idx;
            busy_d[win_rd] = 1'b1;
         end else if (sb.issue_ready) begin
            valid_d = 1'b0;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_async_n) begin
      if (!reset_async_n) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         rd_q    <= '0;
         idx_q   <= '0;
         busy_q  <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         rd_q    <= rd_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
      end
   end

   assign sb.issue_valid = valid_q;
   assign sb.issue_instr = instr_q;
   assign sb.issue_rd    = rd_q;
   assign sb.issue_idx   = idx_q;
   assign sb.busy        = busy_q;

endmodule

// File: tb/tb_scoreboard_issue_select.sv
// Directed-vector bench for scoreboard_issue_select with hand-computed expectations.
module tb_scoreboard_issue_select;

   logic clock;
   logic reset_async_n;
   int   n_vec;
   int   n_bad;

   scoreboard_issue_select_if #(.DEPTH(4), .IDXW(2)) sb ();

   scoreboard_issue_select #(.DEPTH(4), .IDXW(2)) dut (
      .clock        (clock),
      .reset_async_n(reset_async_n),
      .sb           (sb)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ent(input int i, input logic [31:0] ins, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] rd, input logic run);
      sb.ent_instr[i*32 +: 32] = ins;
      sb.ent_rs1[i*5 +: 5]     = r1;
      sb.ent_rs2[i*5 +: 5]     = r2;
      sb.ent_rd[i*5 +: 5]      = rd;
      sb.ent_running[i]        = run;
   endtask

   task automatic clr_all();
      sb.ent_instr   = '0;
      sb.ent_rs1     = '0;
      sb.ent_rs2     = '0;
      sb.ent_rd      = '0;
      sb.ent_running = '0;
   endtask

   localparam logic [31:0] I_T2 = 32'h0020_8033;
   localparam logic [31:0] I_3A = 32'h0000_1111;
   localparam logic [31:0] I_3B = 32'h0002_8333;
   localparam logic [31:0] I_P  = 32'h0000_0aaa;
   localparam logic [31:0] I_A  = 32'h0000_a001;
   localparam logic [31:0] I_B  = 32'h0000_b002;
   localparam logic [31:0] I_C  = 32'h0000_c003;
   localparam logic [31:0] I_G  = 32'h0000_0ee7;
   localparam logic [31:0] I_D  = 32'h0000_d004;
   localparam logic [31:0] I_E  = 32'h0000_e005;
   localparam logic [31:0] I_F  = 32'h0000_f006;

   initial begin
      n_vec = 0;
      n_bad = 0;
      reset_async_n  = 1'b0;
      sb.flush       = 1'b0;
      sb.issue_ready = 1'b0;
      sb.wb_valid    = 1'b0;
      sb.wb_rd       = '0;
      clr_all();

      // 1. reset: a ready candidate must not start while reset is held
      set_ent(0, I_T2, 1, 2, 3, 1'b0);
      #3;
      chk("rst_start_held", 32'(sb.issue_start), 32'h0);
      chk("rst_valid_held", 32'(sb.issue_valid), 32'h0);
      chk("rst_busy_held",  sb.busy, 32'h0);
      clr_all();
      repeat (2) tick();
      reset_async_n = 1'b1;
      #1;
      chk("rst_valid", 32'(sb.issue_valid), 32'h0);
      chk("rst_busy",  sb.busy, 32'h0);
      chk("rst_start", 32'(sb.issue_start), 32'h0);
      chk("rst_instr", sb.issue_instr, 32'h0);
      tick();

      // 2. single entry
      sb.issue_ready = 1'b1;
      set_ent(0, I_T2, 1, 2, 3, 1'b0);
      #1;
      chk("t2_start", 32'(sb.issue_start), 32'h1);
      tick();
      chk("t2_valid", 32'(sb.issue_valid), 32'h1);
      chk("t2_instr", sb.issue_instr, I_T2);
      chk("t2_idx",   32'(sb.issue_idx), 32'h0);
      chk("t2_rd",    32'(sb.issue_rd), 32'h3);
      chk("t2_busy",  sb.busy, 32'h0000_0008);
      sb.ent_running[0] = 1'b1;
      #1;
      chk("t2_nostart", 32'(sb.issue_start), 32'h0);
      tick();
      chk("t2_drain", 32'(sb.issue_valid), 32'h0);
      chk("t2_busy_hold", sb.busy, 32'h0000_0008);

      // 3. RAW hold against in-flight register
      sb.wb_valid = 1'b1;
      sb.wb_rd    = 5'd3;
      tick();
      sb.wb_valid = 1'b0;
      chk("t3_wbclr", sb.busy, 32'h0);
      set_ent(0, I_3A, 1, 2, 5, 1'b0);
      #1;
      chk("t3_e0_start", 32'(sb.issue_start), 32'h1);
      tick();
      chk("t3_busy5", sb.busy, 32'h0000_0020);
      sb.ent_running[0] = 1'b1;
      set_ent(1, I_3B, 5, 0, 6, 1'b0);
      #1;
      chk("t3_blocked", 32'(sb.issue_start), 32'h0);
      tick();
      chk("t3_blocked2", 32'(sb.issue_start), 32'h0);
      sb.wb_valid = 1'b1;
      sb.wb_rd    = 5'd5;
      #1;
      chk("t3_nobypass", 32'(sb.issue_start), 32'h0);
      tick();
      sb.wb_valid = 1'b0;
      #1;
      chk("t3_busy_clr", sb.busy, 32'h0);
      chk("t3_e1_start", 32'(sb.issue_start), 32'h2);
      tick();
      chk("t3_idx",   32'(sb.issue_idx), 32'h1);
      chk("t3_instr", sb.issue_instr, I_3B);
      chk("t3_busy6", sb.busy, 32'h0000_0040);

      // 4. age ordering and older-entry hazards
      clr_all();
      sb.wb_valid = 1'b1;
      sb.wb_rd    = 5'd6;
      tick();
      sb.wb_valid = 1'b0;
      set_ent(3, I_P, 1, 2, 10, 1'b0);
      #1;
      chk("t4_e3_start", 32'(sb.issue_start), 32'h8);
      tick();
      clr_all();
      chk("t4_busy10", sb.busy, 32'h0000_0400);
      set_ent(0, I_A, 10, 0, 7, 1'b0);
      set_ent(1, I_B, 1, 7, 8, 1'b0);
      #1;
      chk("t4_raw", 32'(sb.issue_start), 32'h0);
      set_ent(0, I_A, 9, 10, 0, 1'b0);
      set_ent(1, I_B, 1, 2, 9, 1'b0);
      #1;
      chk("t4_war", 32'(sb.issue_start), 32'h0);
      set_ent(2, I_C, 11, 12, 13, 1'b0);
      #1;
      chk("t4_young", 32'(sb.issue_start), 32'h4);
      tick();
      chk("t4_idx",   32'(sb.issue_idx), 32'h2);
      chk("t4_instr", sb.issue_instr, I_C);
      chk("t4_busy",  sb.busy, 32'h0000_2400);

      // 5. backpressure, then back-to-back reload
      sb.issue_ready    = 1'b0;
      sb.ent_running[2] = 1'b1;
      set_ent(1, I_B, 1, 2, 14, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_start", 32'(sb.issue_start), 32'h0);
         chk("bp_valid", 32'(sb.issue_valid), 32'h1);
         chk("bp_instr", sb.issue_instr, I_C);
         chk("bp_idx",   32'(sb.issue_idx), 32'h2);
         tick();
      end
      sb.issue_ready = 1'b1;
      #1;
      chk("bp_go", 32'(sb.issue_start), 32'h2);
      tick();
      chk("bp_valid2", 32'(sb.issue_valid), 32'h1);
      chk("bp_idx2",   32'(sb.issue_idx), 32'h1);
      chk("bp_instr2", sb.issue_instr, I_B);
      chk("bp_busy",   sb.busy, 32'h0000_6400);

      // 6. flush gates a free-slot candidate and squashes state
      sb.ent_running[1] = 1'b1;
      set_ent(3, I_G, 1, 2, 0, 1'b0);
      sb.flush = 1'b1;
      #1;
      chk("fl1_start", 32'(sb.issue_start), 32'h0);
      tick();
      sb.flush = 1'b0;
      chk("fl1_valid", 32'(sb.issue_valid), 32'h0);
      chk("fl1_busy",  sb.busy, 32'h0);
      clr_all();
      set_ent(0, I_D, 1, 2, 3, 1'b0);
      set_ent(1, I_E, 4, 5, 7, 1'b0);
      #1;
      chk("fl_e0_start", 32'(sb.issue_start), 32'h1);
      tick();
      chk("fl_busy8", sb.busy, 32'h0000_0008);
      sb.ent_running[0] = 1'b1;
      #1;
      chk("fl_e1_start", 32'(sb.issue_start), 32'h2);
      tick();
      chk("fl_busy88", sb.busy, 32'h0000_0088);
      chk("fl_valid",  32'(sb.issue_valid), 32'h1);
      sb.issue_ready    = 1'b0;
      sb.ent_running[1] = 1'b1;
      set_ent(2, I_F, 1, 2, 0, 1'b0);
      sb.flush    = 1'b1;
      sb.wb_valid = 1'b1;
      sb.wb_rd    = 5'd3;
      #1;
      chk("fl2_start", 32'(sb.issue_start), 32'h0);
      tick();
      sb.flush    = 1'b0;
      sb.wb_valid = 1'b0;
      chk("fl2_valid", 32'(sb.issue_valid), 32'h0);
      chk("fl2_busy",  sb.busy, 32'h0);
      sb.issue_ready = 1'b1;
      #1;
      chk("rd0_start", 32'(sb.issue_start), 32'h4);
      tick();
      chk("rd0_valid", 32'(sb.issue_valid), 32'h1);
      chk("rd0_instr", sb.issue_instr, I_F);
      chk("rd0_rd",    32'(sb.issue_rd), 32'h0);
      chk("rd0_busy",  sb.busy, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
